// File: rtl/mem_port_arbiter.sv
// Fetch/data arbiter sharing one fixed-latency single-port memory.
// Define ARB_ROUND_ROBIN_EN for alternating grants on collisions.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int WAIT_STATES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic [DATA_WIDTH-1:0] if_rdata,
  output logic                  if_valid,
  input  logic                  dm_req,
  input  logic [3:0]            dm_we,
  input  logic [ADDR_WIDTH-1:0] dm_addr,
  input  logic [DATA_WIDTH-1:0] dm_wdata,
  output logic [DATA_WIDTH-1:0] dm_rdata,
  output logic                  dm_valid,
  output logic                  mem_en,
  output logic [3:0]            mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  cpu_stall
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_e;

  localparam logic [3:0] CntLoad = 4'(WAIT_STATES - 1);

  state_e     state_q;
  logic [3:0] cnt_q;
  logic       own_dm_q;
  logic       store_q;
  logic       grant_dm;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_dm_q;

  // On a collision, hand the port to whoever did not own the last access.
  assign grant_dm = dm_req & ~(if_req & last_dm_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_dm_q <= 1'b0;
    end else if (state_q == S_ISSUE) begin
      last_dm_q <= own_dm_q;
    end
  end
`else
  assign grant_dm = dm_req;
`endif

  assign cpu_stall = (if_req & ~if_valid) | (dm_req & ~dm_valid);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      own_dm_q  <= 1'b0;
      store_q   <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
      if_valid  <= 1'b0;
      dm_valid  <= 1'b0;
    end else begin
      mem_en   <= 1'b0;
      mem_we   <= '0;
      if_valid <= 1'b0;
      dm_valid <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (if_req | dm_req) begin
            own_dm_q <= grant_dm;
            store_q  <= grant_dm & (|dm_we);
            mem_addr <= grant_dm ? dm_addr : if_addr;
            if (grant_dm) begin
              mem_wdata <= dm_wdata;
            end
            mem_en  <= 1'b1;
            mem_we  <= grant_dm ? dm_we : 4'b0000;
            state_q <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          cnt_q   <= CntLoad;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (cnt_q == 4'd0) begin
            if (!store_q) begin
              if (own_dm_q) begin
                dm_rdata <= mem_rdata;
              end else begin
                if_rdata <= mem_rdata;
              end
            end
            if (own_dm_q) begin
              dm_valid <= 1'b1;
            end else begin
              if_valid <= 1'b1;
            end
            state_q <= S_RESP;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_RESP: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter.
// Memory model returns data exactly WS cycles after the mem_en cycle.
module tb_mem_port_arbiter;

  localparam int WS = 2;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        dm_req;
  logic [3:0]  dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_valid;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        cpu_stall;

  mem_port_arbiter #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .WAIT_STATES(WS)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_rdata (if_rdata),
    .if_valid (if_valid),
    .dm_req   (dm_req),
    .dm_we    (dm_we),
    .dm_addr  (dm_addr),
    .dm_wdata (dm_wdata),
    .dm_rdata (dm_rdata),
    .dm_valid (dm_valid),
    .mem_en   (mem_en),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .cpu_stall(cpu_stall)
  );

  typedef struct {
    bit          dm;
    logic [31:0] addr;
    logic [3:0]  we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          cyc;
  } exp_t;

  exp_t iss_q[$];
  exp_t rsp_q[$];

  int          n_chk = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          vcount = 0;
  bit          last_dm = 0;
  logic [31:0] exp_dm = '0;
  int          rd_cnt = -1;
  logic [31:0] rd_addr = '0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h40) return 32'h8C220004;
    return {~a[15:0], a[15:0]} ^ 32'h0F0F_0000;
  endfunction

  always @(posedge clk) begin
    mem_rdata <= 32'hDEAD_BEEF;
    if (mem_en) begin
      if (WS == 1) mem_rdata <= mem_word(mem_addr);
      else begin
        rd_cnt  <= WS - 2;
        rd_addr <= mem_addr;
      end
    end else if (rd_cnt > 0) begin
      rd_cnt <= rd_cnt - 1;
    end else if (rd_cnt == 0) begin
      mem_rdata <= mem_word(rd_addr);
      rd_cnt    <= -1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h @cyc %0d", tag, got, exp, cyc);
    end
  endtask

  task automatic push(input bit dm, input logic [31:0] addr,
                      input logic [3:0] we, input logic [31:0] wd,
                      input int ic);
    exp_t e;
    e.dm    = dm;
    e.addr  = addr;
    e.we    = dm ? we : 4'b0000;
    e.wdata = wd;
    e.cyc   = ic;
    iss_q.push_back(e);
    if (dm && we != 4'b0000) e.rdata = exp_dm;
    else e.rdata = mem_word(addr);
    if (dm && we == 4'b0000) exp_dm = e.rdata;
    e.cyc = ic + WS + 1;
    rsp_q.push_back(e);
    last_dm = dm;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      if (mem_en) begin
        if (iss_q.size() == 0) chk("iss_unexp", {31'd0, mem_en}, 0);
        else begin
          e = iss_q.pop_front();
          chk("iss_cyc", cyc, e.cyc);
          chk("mem_addr", mem_addr, e.addr);
          chk("mem_we", {28'd0, mem_we}, {28'd0, e.we});
          if (e.we != 4'b0000) chk("mem_wdata", mem_wdata, e.wdata);
        end
      end
      if (if_valid || dm_valid) begin
        vcount++;
        if (rsp_q.size() == 0)
          chk("rsp_unexp", {30'd0, if_valid, dm_valid}, 0);
        else begin
          e = rsp_q.pop_front();
          chk("rsp_owner", {30'd0, if_valid, dm_valid},
              e.dm ? 32'd1 : 32'd2);
          chk("rsp_cyc", cyc, e.cyc);
          if (e.dm) chk("dm_rdata", dm_rdata, e.rdata);
          else chk("if_rdata", if_rdata, e.rdata);
        end
      end
    end
  end

  task automatic xact(input bit f_en, input logic [31:0] f_addr,
                      input bit d_en, input logic [3:0] d_we,
                      input logic [31:0] d_addr,
                      input logic [31:0] d_wdata, input int d_drop);
    int c;
    int ic;
    int f_vc;
    int d_vc;
    int budget;
    bit first_dm;
    bit f_seen;
    bit d_seen;
    bit f_done;
    bit d_done;
    @(posedge clk); #1;
    c = cyc;
    f_vc = -1;
    d_vc = -1;
    if_req = f_en;
    if_addr = f_addr;
    dm_req = d_en;
    dm_we = d_we;
    dm_addr = d_addr;
    dm_wdata = d_wdata;
`ifdef ARB_ROUND_ROBIN_EN
    first_dm = d_en && (!f_en || !last_dm);
`else
    first_dm = d_en;
`endif
    ic = c + 1;
    if (first_dm) begin
      push(1, d_addr, d_we, d_wdata, ic);
      d_vc = ic + WS + 1;
      if (f_en) begin
        push(0, f_addr, 4'b0000, '0, ic + WS + 3);
        f_vc = ic + 2 * WS + 4;
      end
    end else begin
      push(0, f_addr, 4'b0000, '0, ic);
      f_vc = ic + WS + 1;
      if (d_en) begin
        push(1, d_addr, d_we, d_wdata, ic + WS + 3);
        d_vc = ic + 2 * WS + 4;
      end
    end
    f_seen = 0;
    d_seen = 0;
    f_done = !f_en;
    d_done = !d_en;
    budget = 4 * (WS + 3) + 10;
    while (!(f_done && d_done) && budget > 0) begin
      @(negedge clk);
      chk("cpu_stall", {31'd0, cpu_stall},
          {31'd0, (if_req && cyc != f_vc) || (dm_req && cyc != d_vc)});
      if (if_valid) f_seen = 1;
      if (dm_valid) d_seen = 1;
      @(posedge clk); #1;
      if (f_seen) begin
        if_req = 0;
        f_done = 1;
      end
      if (d_seen) begin
        dm_req = 0;
        d_done = 1;
      end
      if (d_drop >= 0 && cyc == c + d_drop) dm_req = 0;
      budget--;
    end
    chk("done", {30'd0, f_done, d_done}, 32'd3);
    @(negedge clk);
    chk("stall_idle", {31'd0, cpu_stall}, 0);
  endtask

  initial begin : stim
    int v0;
    rst = 1'b0;
    if_req = 0;
    if_addr = '0;
    dm_req = 0;
    dm_we = '0;
    dm_addr = '0;
    dm_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_en", {31'd0, mem_en}, 0);
    chk("rst_mem_we", {28'd0, mem_we}, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_dm_rdata", dm_rdata, 0);
    chk("rst_valids", {30'd0, if_valid, dm_valid}, 0);
    chk("rst_stall", {31'd0, cpu_stall}, 0);
    rst = 1'b1;

    xact(1, 32'h140, 1, 4'b0000, 32'h240, '0, -1);
    xact(1, 32'h40, 0, 4'b0000, '0, '0, -1);
    xact(0, '0, 1, 4'b0000, 32'h200, '0, -1);
    xact(0, '0, 1, 4'b0001, 32'h100, 32'h0000_00A5, -1);
    xact(0, '0, 1, 4'b0011, 32'h104, 32'h0000_BEEF, -1);
    xact(0, '0, 1, 4'b1111, 32'h108, 32'h1234_5678, -1);
    xact(1, 32'h44, 1, 4'b0000, 32'h304, '0, -1);
    xact(1, 32'h48, 1, 4'b0000, 32'h308, '0, -1);
    xact(0, '0, 1, 4'b0000, 32'h30C, '0, -1);
    xact(1, 32'h4C, 1, 4'b1111, 32'h310, 32'hCAFE_F00D, -1);
    xact(1, 32'h50, 1, 4'b0000, 32'h314, '0, -1);
    xact(0, '0, 1, 4'b0000, 32'h300, '0, 2);

    @(posedge clk); #1;
    if_addr = 32'h80;
    if_req = 1;
    push(0, 32'h80, 4'b0000, '0, cyc + 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    if_req = 0;
    #1;
    chk("mid_mem_en", {31'd0, mem_en}, 0);
    chk("mid_mem_we", {28'd0, mem_we}, 0);
    chk("mid_mem_addr", mem_addr, 0);
    chk("mid_mem_wdata", mem_wdata, 0);
    chk("mid_if_rdata", if_rdata, 0);
    chk("mid_dm_rdata", dm_rdata, 0);
    chk("mid_valids", {30'd0, if_valid, dm_valid}, 0);
    rsp_q.delete();
    last_dm = 0;
    exp_dm = '0;
    @(posedge clk); #1;
    rst = 1'b1;
    v0 = vcount;
    repeat (6) @(posedge clk);
    #1;
    chk("post_rst_valid", vcount - v0, 0);
    xact(1, 32'h40, 0, 4'b0000, '0, '0, -1);
    xact(1, 32'h60, 1, 4'b0000, 32'h260, '0, -1);

    repeat (3) @(posedge clk);
    #1;
    chk("iss_q_left", iss_q.size(), 0);
    chk("rsp_q_left", rsp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
